// File: rtl/decoder_seq_if.sv
// Command/beat bundle between a decoder_seq and its upstream/downstream logic.
// The master side issues codes and accepts beats; the slave side is the decoder.
interface decoder_seq_if #(
    parameter int AW   = 5,
    parameter int NOUT = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   A;
    logic [1:0]      mode;
    logic [NOUT-1:0] Z;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            err;

    modport master (
        output in_valid, A, mode, out_ready,
        input  in_ready, Z, out_valid, out_last, err
    );

    modport slave (
        input  in_valid, A, mode, out_ready,
        output in_ready, Z, out_valid, out_last, err
    );
endinterface

// File: rtl/decoder_seq.sv
// Registered binary-to-N decoder with one-hot, thermometer and walking-one scan
// modes, valid/ready on both sides and a one-beat output register.
module decoder_seq #(
    parameter int AW   = 5,
    parameter int NOUT = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    decoder_seq_if.slave  bus
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state, state_n;
    logic [NOUT-1:0] z_q, z_n;
    logic [NOUT-1:0] one_hot, therm;
    logic            err_q, err_n;
    logic            last_q, last_n;
    logic            valid_q, valid_n;
    logic            ready_en;
    logic [AW-1:0]   idx_q, idx_n;
    logic [AW-1:0]   end_q, end_n;
    logic [AW-1:0]   idx_inc;
    logic            in_range;
    logic            in_ready;
    logic            accept;
    logic            out_hs;

    // ready_en keeps in_ready low during reset and for the first cycle after release
    assign in_ready      = ready_en & (state == IDLE) & (!valid_q | bus.out_ready);
    assign accept        = bus.in_valid & in_ready;
    assign out_hs        = valid_q & bus.out_ready;
    assign idx_inc       = idx_q + AW'(1);
    assign in_range      = int'(bus.A) < NOUT;

    assign bus.in_ready  = in_ready;
    assign bus.Z         = z_q;
    assign bus.err       = err_q;
    assign bus.out_last  = last_q;
    assign bus.out_valid = valid_q;

    always_comb begin
        one_hot = '0;
        therm   = '0;
        for (int i = 0; i < NOUT; i++) begin
            one_hot[i] = (i == int'(bus.A));
            therm[i]   = (i <= int'(bus.A));
        end
    end

    always_comb begin
        state_n = state;
        z_n     = z_q;
        err_n   = err_q;
        last_n  = last_q;
        valid_n = valid_q;
        idx_n   = idx_q;
        end_n   = end_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    valid_n = 1'b1;
                    last_n  = 1'b1;
                    err_n   = 1'b0;
                    z_n     = '0;
                    case (bus.mode)
                        2'b00: begin
                            if (in_range) z_n = one_hot;
                            else          err_n = 1'b1;
                        end
                        2'b01: begin
                            if (in_range) begin
                                z_n = therm;
                            end else begin
                                z_n   = '1;
                                err_n = 1'b1;
                            end
                        end
                        2'b10: begin
                            if (in_range) begin
                                z_n    = {{(NOUT-1){1'b0}}, 1'b1};
                                idx_n  = '0;
                                end_n  = bus.A;
                                last_n = (bus.A == '0);
                                if (bus.A != '0) state_n = SCAN;
                            end else begin
                                err_n = 1'b1;
                            end
                        end
                        default: err_n = 1'b1;
                    endcase
                end else if (out_hs) begin
                    valid_n = 1'b0;
                end
            end
            SCAN: begin
                // z_q always holds 1<<idx here, so a left shift yields 1<<(idx+1)
                if (out_hs) begin
                    idx_n  = idx_inc;
                    z_n    = z_q << 1;
                    last_n = (idx_inc == end_q);
                    if (idx_inc == end_q) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            z_q      <= '0;
            err_q    <= 1'b0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            end_q    <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_n;
            z_q      <= z_n;
            err_q    <= err_n;
            last_q   <= last_n;
            valid_q  <= valid_n;
            idx_q    <= idx_n;
            end_q    <= end_n;
            ready_en <= 1'b1;
        end
    end

endmodule
